mem_req_arbiter: RTL and testbench

- Shares one single-beat AXI3 master port between the instruction cache and the data cache miss/write-through paths.
- Fixed-priority grant (data over instruction) and a multi-state transaction FSM.
- Returns read data with a one-cycle done pulse to the granted requester.
- Sits between the two L1 caches and the top-level AXI interface.

---
 rtl/mem_req_arbiter_pkg.sv | 31 +++
 rtl/mem_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_pkg
// Description : Shared types and constants for the L1-to-AXI request arbiter.
//               Holds the transaction FSM encoding, the fixed single-beat AXI
//               attributes and the default transaction IDs.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_R    = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_B    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Every transfer is a single 32-bit beat
  localparam logic [3:0] LEN_1BEAT  = 4'd0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Default AXI IDs for each requester
  localparam int DEF_INST_ID = 0;
  localparam int DEF_DATA_ID = 1;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Shares one single-beat AXI3 master port between the I-cache
//               (reads) and the D-cache (reads and writes). Data side has
//               fixed priority; one transaction is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = DEF_INST_ID,
  parameter int DATA_ID = DEF_DATA_ID
) (
  input  logic            clk,
  input  logic            resetn,
  // Instruction cache side
  input  logic            inst_req,
  input  logic [31:0]     inst_addr,
  output logic [31:0]     inst_rdata,
  output logic            inst_dok,
  // Data cache side
  input  logic            data_req,
  input  logic [3:0]      data_wen,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_dok,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  // AXI write data
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  state_t      state_q, state_d;
  logic        owner_q;          // 1 = data cache, 0 = instruction cache
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        latch_req;        // IDLE is leaving; capture the winning request
  logic        latch_owner;

  // Response IDs/status are not used: only one transaction is ever outstanding
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  // Fixed single-beat attributes and latched request fields
  assign arlen   = LEN_1BEAT;
  assign awlen   = LEN_1BEAT;
  assign arsize  = SIZE_WORD;
  assign awsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign arid    = owner_q ? ID_W'(DATA_ID) : ID_W'(INST_ID);
  assign awid    = ID_W'(DATA_ID);

  // Caches write on dok, so the fresh beat is forwarded during that cycle
  assign inst_rdata = inst_dok ? rdata : inst_rdata_q;
  assign data_rdata = (data_dok && state_q == S_RD_R) ? rdata : data_rdata_q;

  // Next-state, handshake flags and channel outputs
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    latch_req   = 1'b0;
    latch_owner = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    inst_dok    = 1'b0;
    data_dok    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (data_req) begin
          latch_req   = 1'b1;
          latch_owner = 1'b1;
          state_d     = (|data_wen) ? S_WR_AW_W : S_RD_AR;
        end else if (inst_req) begin
          latch_req = 1'b1;
          state_d   = S_RD_AR;
        end
      end
      S_RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_R;
      end
      S_RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          inst_dok = ~owner_q;
          data_dok = owner_q;
          state_d  = S_DONE;
        end
      end
      S_WR_AW_W: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          data_dok = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request fields and per-owner read data registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (latch_req) begin
        owner_q <= latch_owner;
        addr_q  <= latch_owner ? data_addr : inst_addr;
        wen_q   <= latch_owner ? data_wen : 4'd0;
        wdata_q <= data_wdata;
      end
      if (state_q == S_RD_R && rvalid) begin
        if (owner_q) data_rdata_q <= rdata;
        else         inst_rdata_q <= rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed self-checking bench for mem_req_arbiter. Inputs change
//               1 ns after the rising edge, outputs are compared 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_req_arbiter;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            inst_req;
  logic [31:0]     inst_addr;
  logic [31:0]     inst_rdata;
  logic            inst_dok;
  logic            data_req;
  logic [3:0]      data_wen;
  logic [31:0]     data_addr;
  logic [31:0]     data_wdata;
  logic [31:0]     data_rdata;
  logic            data_dok;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  int n_checks = 0;
  int n_errors = 0;

  mem_req_arbiter #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_dok(inst_dok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_dok(data_dok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of every handshake/strobe output: {arvalid,rready,awvalid,wvalid,bready,inst_dok,data_dok}
  function automatic logic [31:0] ctl();
    return {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_dok, data_dok};
  endfunction

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wen = '0;
    data_addr = '0; data_wdata = '0; arready = 1'b0; rid = '0; rdata = '0; rresp = '0;
    rlast = 1'b1; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0;
    bvalid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("reset_ctl", ctl(), 32'h0);
    check("reset_inst_rdata", inst_rdata, 32'h0);
    check("reset_data_rdata", data_rdata, 32'h0);
    resetn = 1'b1;
    tick();

    // ---------------- single instruction read ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    tick();                                   // RD_AR
    check("t1_ar_ctl", ctl(), 32'h40);
    check("t1_araddr", araddr, 32'hBFC0_0000);
    check("t1_arid", 32'(arid), 32'd0);
    check("t1_attr", {17'd0, arlen, arsize, arburst, awlen, awsize, awburst, wlast},
          {17'd0, 4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1});
    arready = 1'b1;
    tick();                                   // RD_R
    arready = 1'b0;
    check("t1_r_ctl_pre", ctl(), 32'h20);
    rvalid = 1'b1; rdata = 32'h3C08_BFAF;
    #1;
    check("t1_r_ctl_dok", ctl(), 32'h22);
    check("t1_inst_rdata", inst_rdata, 32'h3C08_BFAF);
    tick();                                   // DONE, request still held
    rvalid = 1'b0; rdata = '0;
    check("t1_done_ctl", ctl(), 32'h0);
    check("t1_rdata_hold", inst_rdata, 32'h3C08_BFAF);
    inst_req = 1'b0;
    tick();                                   // IDLE
    check("t1_idle_ctl", ctl(), 32'h0);

    // ---------------- simultaneous requests: data wins ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h8000_1000;
    tick();                                   // RD_AR (data)
    check("t2_d_arid", 32'(arid), 32'd1);
    check("t2_d_araddr", araddr, 32'h8000_1000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    check("t2_d_ctl_dok", ctl(), 32'h21);
    check("t2_d_rdata", data_rdata, 32'hDEAD_BEEF);
    check("t2_i_rdata_untouched", inst_rdata, 32'h3C08_BFAF);
    tick();                                   // DONE
    rvalid = 1'b0; data_req = 1'b0;
    check("t2_done_ctl", ctl(), 32'h0);
    tick();                                   // IDLE samples inst_req
    check("t2_idle_ctl", ctl(), 32'h0);
    tick();                                   // RD_AR (inst)
    check("t2_i_ar_ctl", ctl(), 32'h40);
    check("t2_i_arid", 32'(arid), 32'd0);
    check("t2_i_araddr", araddr, 32'hBFC0_0004);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_2222;
    #1;
    check("t2_i_ctl_dok", ctl(), 32'h22);
    check("t2_i_rdata", inst_rdata, 32'h1111_2222);
    check("t2_d_rdata_hold", data_rdata, 32'hDEAD_BEEF);
    tick();
    rvalid = 1'b0; inst_req = 1'b0;
    tick();

    // ---------------- data write, W handshake before AW ----------------
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_2000; data_wdata = 32'h1234_5678;
    tick();                                   // cycle 1
    check("t3_c1_ctl", ctl(), 32'h18);
    check("t3_awaddr", awaddr, 32'h8000_2000);
    check("t3_awid", 32'(awid), 32'd1);
    check("t3_wdata", wdata, 32'h1234_5678);
    check("t3_wstrb", 32'(wstrb), 32'h3);
    wready = 1'b1;
    tick();                                   // cycle 2
    wready = 1'b0;
    check("t3_c2_ctl", ctl(), 32'h10);
    tick();                                   // cycle 3
    check("t3_c3_ctl", ctl(), 32'h10);
    awready = 1'b1;
    tick();                                   // WR_B
    awready = 1'b0;
    check("t3_b_ctl", ctl(), 32'h04);
    bvalid = 1'b1;
    #1;
    check("t3_b_ctl_dok", ctl(), 32'h05);
    tick();                                   // DONE
    bvalid = 1'b0; data_req = 1'b0; data_wen = 4'd0;
    check("t3_done_ctl", ctl(), 32'h0);
    tick();

    // ---------------- read address backpressure ----------------
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_stall%0d_ctl", i), ctl(), 32'h40);
      check($sformatf("t4_stall%0d_araddr", i), araddr, 32'h0040_0000);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t4_r_ctl", ctl(), 32'h20);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    check("t4_ctl_dok", ctl(), 32'h22);
    check("t4_rdata", inst_rdata, 32'hCAFE_F00D);
    tick();
    rvalid = 1'b0;
    check("t4_done_ctl", ctl(), 32'h0);
    inst_req = 1'b0;
    tick();
    check("t4_no_reissue", ctl(), 32'h0);

    // ---------------- asynchronous reset during WR_B ----------------
    data_req = 1'b1; data_wen = 4'b1111; data_addr = 32'h8000_3000; data_wdata = 32'hAA55_AA55;
    tick();
    awready = 1'b1; wready = 1'b1;
    tick();                                   // WR_B
    awready = 1'b0; wready = 1'b0;
    check("t5_b_ctl", ctl(), 32'h04);
    bvalid = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    check("t5_async_ctl", ctl(), 32'h0);
    check("t5_async_rdata", data_rdata, 32'h0);
    bvalid = 1'b0;
    #1;
    resetn = 1'b1;
    tick();                                   // fresh write issues from IDLE
    check("t5_new_aw_ctl", ctl(), 32'h18);
    check("t5_new_awaddr", awaddr, 32'h8000_3000);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    #1;
    check("t5_new_dok", ctl(), 32'h05);
    tick();
    bvalid = 1'b0; data_req = 1'b0; data_wen = 4'd0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
